// File: rtl/reflet_timer_sched_pkg.sv
// Shared encodings for the reflet timer scheduler: channel modes and channel states.
package reflet_timer_sched_pkg;

  typedef enum logic [1:0] {
    ModeOff      = 2'b00,
    ModeOneShot  = 2'b01,
    ModePeriodic = 2'b10,
    ModeRsvd     = 2'b11
  } mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Only one-shot and periodic arm a channel; reserved behaves like off.
  function automatic logic mode_arms(mode_e m);
    return (m == ModeOneShot) || (m == ModePeriodic);
  endfunction

endpackage

// File: rtl/reflet_timer_channel.sv
// One timer channel: tick counter, stored period/mode, IDLE/RUN state and irq/overrun flags.
module reflet_timer_channel
  import reflet_timer_sched_pkg::*;
#(
  parameter int unsigned size = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic            i_we,
  input  logic [size-1:0] i_period,
  input  mode_e           i_mode,
  input  logic            i_ack,
  output logic            o_irq,
  output logic            o_overrun,
  output logic            o_running
);

  localparam logic [size-1:0] One = {{(size - 1){1'b0}}, 1'b1};

  state_e          r_state;
  state_e          w_state_nxt;
  logic [size-1:0] r_cnt;
  logic [size-1:0] w_cnt_nxt;
  logic [size-1:0] r_period;
  mode_e           r_mode;
  logic            r_irq;
  logic            w_irq_nxt;
  logic            r_overrun;
  logic            w_overrun_nxt;
  logic            w_expire;

  // A write in the same cycle suppresses both counting and expiry.
  assign w_expire = (r_state == StRun) && i_tick && !i_we && (r_cnt == r_period - One);

  // State register plus the channel's datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_period  <= '0;
      r_mode    <= ModeOff;
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_irq     <= w_irq_nxt;
      r_overrun <= w_overrun_nxt;
      if (i_we) begin
        r_period <= i_period;
        r_mode   <= i_mode;
      end
    end
  end

  // Next state: a write re-arms or disarms; a one-shot expiry drops back to idle.
  always_comb begin
    w_state_nxt = r_state;
    if (i_we) begin
      w_state_nxt = (mode_arms(i_mode) && (i_period != '0)) ? StRun : StIdle;
    end else if (w_expire && (r_mode != ModePeriodic)) begin
      w_state_nxt = StIdle;
    end
  end

  // Counter and pending-flag updates; expiry takes precedence over acknowledge.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_irq_nxt     = r_irq;
    w_overrun_nxt = r_overrun;
    if (i_we) begin
      w_cnt_nxt = '0;
    end else if ((r_state == StRun) && i_tick) begin
      w_cnt_nxt = w_expire ? '0 : r_cnt + One;
    end
    if (w_expire) begin
      w_irq_nxt     = 1'b1;
      w_overrun_nxt = i_ack ? 1'b0 : (r_overrun | r_irq);
    end else if (i_ack) begin
      w_irq_nxt     = 1'b0;
      w_overrun_nxt = 1'b0;
    end
  end

  // Outputs are straight from state and flag registers.
  always_comb begin
    o_running = (r_state == StRun);
    o_irq     = r_irq;
    o_overrun = r_overrun;
  end

endmodule

// File: rtl/reflet_timer_sched.sv
// Multi-channel timer scheduler: shared prescaler, configuration write decode, channel array.
module reflet_timer_sched
  import reflet_timer_sched_pkg::*;
#(
  parameter int unsigned size     = 32,
  parameter int unsigned channels = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [size-1:0]             prescale,
  input  logic                        cfg_we,
  input  logic [$clog2(channels)-1:0] cfg_sel,
  input  logic [size-1:0]             cfg_period,
  input  logic [1:0]                  cfg_mode,
  input  logic [channels-1:0]         irq_ack,
  output logic                        tick,
  output logic [channels-1:0]         irq,
  output logic [channels-1:0]         overrun,
  output logic [channels-1:0]         running
);

  localparam int unsigned SelW = $clog2(channels);
  localparam logic [size-1:0] One = {{(size - 1){1'b0}}, 1'b1};

  logic [size-1:0]     r_pcnt;
  logic                w_tick;
  logic                w_sel_ok;
  logic [channels-1:0] w_we;

  // Comparing with >= means lowering prescale below pcnt ticks at once instead of wrapping.
  assign w_tick = !reset && (r_pcnt >= prescale);
  assign tick   = w_tick;

  // Prescaler counter: restart after each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + One;
    end
  end

  // Selects past the last channel are dropped (matters when channels is not a power of two).
  assign w_sel_ok = (32'(cfg_sel) < channels);

  for (genvar g = 0; g < channels; g++) begin : g_ch
    assign w_we[g] = cfg_we && w_sel_ok && (cfg_sel == SelW'(g));

    reflet_timer_channel #(
      .size(size)
    ) u_channel (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_tick   (w_tick),
      .i_we     (w_we[g]),
      .i_period (cfg_period),
      .i_mode   (mode_e'(cfg_mode)),
      .i_ack    (irq_ack[g]),
      .o_irq    (irq[g]),
      .o_overrun(overrun[g]),
      .o_running(running[g])
    );
  end

endmodule

// File: doc/reflet_timer_sched.md
REFLET_TIMER_SCHED -- requirements
Module: reflet_timer_sched

Interface
REQ-001 SHALL have parameter size, default 32, giving the width of prescaler and period values.
REQ-002 SHALL have parameter channels, default 4, giving the number of timer channels (2..16).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port prescale, input, size, shared tick divider: one tick every prescale+1 clk cycles.
REQ-006 SHALL have port cfg_we, input, 1, configuration write strobe for one cycle.
REQ-007 SHALL have port cfg_sel, input, clog2(channels), channel addressed by cfg_we.
REQ-008 SHALL have port cfg_period, input, size, expiry period in ticks.
REQ-009 SHALL have port cfg_mode, input, 2, with 00=off, 01=one-shot, 10=periodic, 11=reserved (treated as off).
REQ-010 SHALL have port irq_ack, input, channels, per-channel interrupt acknowledge.
REQ-011 SHALL have port tick, output, 1, high for one cycle per prescaler period.
REQ-012 SHALL have port irq, output, channels, per-channel pending flag.
REQ-013 SHALL have port overrun, output, channels, set when a channel expires while its irq is still pending.
REQ-014 SHALL have port running, output, channels, high while a channel is in state RUN.

Function
REQ-015 Prescaler SHALL use an internal counter pcnt; tick SHALL equal (pcnt >= prescale); pcnt SHALL become 0 on the cycle after tick, else increment.
REQ-016 prescale=0 SHALL give tick high every cycle; lowering prescale below pcnt SHALL give tick on the next cycle, never a wrap through 2^size.
REQ-017 Each channel SHALL hold state IDLE or RUN, a tick counter cnt of size bits, and a stored period and mode.
REQ-018 A cfg_we write to cfg_sel SHALL load period and mode and clear cnt, with the effect visible on the next cycle.
REQ-019 The write SHALL move the channel to RUN if mode is one-shot or periodic and cfg_period != 0, else to IDLE.
REQ-020 In RUN, on a tick, cnt SHALL increment; when cnt == period-1, cnt SHALL become 0 and the channel SHALL expire.
REQ-021 On expiry, irq SHALL be set on the next cycle; if irq was already set, overrun SHALL also be set.
REQ-022 On expiry, a periodic channel SHALL stay in RUN and a one-shot channel SHALL go to IDLE.
REQ-023 period=1 SHALL cause expiry on every tick.
REQ-024 irq_ack[i] SHALL clear irq[i] and overrun[i] on the next cycle; if ack and expiry coincide, the expiry SHALL win, irq SHALL stay 1 and overrun SHALL stay 0.
REQ-025 If a write and a tick hit the same channel in one cycle, the write SHALL win: no increment and no expiry that cycle.
REQ-026 A write SHALL NOT alter irq or overrun; other channels SHALL be unaffected by a write.
REQ-027 cfg_sel >= channels SHALL be ignored.
REQ-028 IDLE channels SHALL ignore ticks and hold cnt.

Reset
REQ-029 On reset, pcnt, every cnt, period and mode SHALL be 0, all channels SHALL be IDLE, and tick, irq, overrun and running SHALL be 0 on the following cycle.
REQ-030 Reset asserted mid-count SHALL override cfg_we and irq_ack in the same cycle.

Structure
REQ-031 The mode encodings (OFF, ONESHOT, PERIODIC) and state encodings (IDLE, RUN) SHALL be constants in the shared reflet package.
REQ-032 Per-channel logic SHALL be a sub-module reflet_timer_channel, instantiated channels times by a generate loop; the prescaler and write decode SHALL stay in the top module.

Verification
REQ-033 The bench SHALL cover: prescale=3 -> tick high exactly 1 cycle in 4, first tick 4 cycles after reset release.
REQ-034 The bench SHALL cover: prescale=0, ch0 periodic period=5, no ack -> irq[0] rises 5 ticks after the write, and overrun[0] rises 5 ticks later.
REQ-035 The bench SHALL cover: ch1 one-shot period=2, prescale=1 -> irq[1] after 2 ticks, running[1] falls in the same cycle, and no further irq after ack.
REQ-036 The bench SHALL cover: irq_ack[0] asserted in the same cycle as ch0 expiry -> irq[0] stays 1 and overrun[0] stays 0.
REQ-037 The bench SHALL cover: a write of period=0 to a running channel -> running drops next cycle, and irq is unchanged.
REQ-038 The bench SHALL cover: reset asserted with ch2 at cnt=3 of period 10 -> all outputs 0 next cycle, and ch2 stays IDLE after reset release.
